// File: rtl/add_subt_pkg.sv
// Shared definitions for the add/subtract arbiter: FSM encoding, default
// significand width and requester-id width.
package add_subt_pkg;

  localparam int SWR_DEF = 26;
  localparam int ID_W    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/add_subt_rr_arb.sv
// Two-requester grant logic. On a tie the requester that did not win last
// time is granted; a constant last_grant of 1 turns this into fixed priority.
module add_subt_rr_arb
  import add_subt_pkg::*;
(
  input  logic [1:0]      valid,
  input  logic [ID_W-1:0] last_grant,
  output logic [1:0]      grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (last_grant == ID_W'(1)) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/add_subt_arbiter.sv
// Shares one external combinational adder between two requesters, one
// operation in flight. Define ADD_SUBT_ARB_RR_EN for round-robin ties,
// otherwise requester 0 always wins a tie.
//
// state | meaning
// IDLE  | waiting for a request; grants and captures operands
// EXEC  | operands drive the adder; results are registered
// RESP  | response presented until rsp_ready_i
module add_subt_arbiter
  import add_subt_pkg::*;
#(
  parameter int SWR = SWR_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid_i,
  output logic           req0_ready_o,
  input  logic [SWR-1:0] req0_op_a_i,
  input  logic [SWR-1:0] req0_op_b_i,
  input  logic           req0_sub_i,
  input  logic           req1_valid_i,
  output logic           req1_ready_o,
  input  logic [SWR-1:0] req1_op_a_i,
  input  logic [SWR-1:0] req1_op_b_i,
  input  logic           req1_sub_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic           rsp_id_o,
  output logic [SWR-1:0] rsp_sum_o,
  output logic           rsp_cout_o,
  output logic [SWR-1:0] rsp_prop_o,
  output logic [SWR-1:0] add_op_a_o,
  output logic [SWR-1:0] add_op_b_o,
  output logic           add_cin_o,
  input  logic [SWR-1:0] add_sum_i,
  input  logic           add_cout_i,
  input  logic [SWR-1:0] add_prop_i
);

  state_t          state;
  logic [SWR-1:0]  op_a_q, op_b_q, sum_q, prop_q;
  logic            cin_q, cout_q, rsp_valid_q;
  logic [ID_W-1:0] id_q, last_grant, gnt_id;
  logic [1:0]      grant;
  logic [SWR-1:0]  sel_a, sel_b;
  logic            sel_sub;

`ifdef ADD_SUBT_ARB_RR_EN
  logic [ID_W-1:0] last_q;
  assign last_grant = last_q;
`else
  assign last_grant = ID_W'(1);
`endif

  add_subt_rr_arb u_arb (
    .valid      ({req1_valid_i, req0_valid_i}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign gnt_id = ID_W'(grant[1]);

  always_comb begin
    sel_a   = req0_op_a_i;
    sel_b   = req0_op_b_i;
    sel_sub = req0_sub_i;
    if (grant[1]) begin
      sel_a   = req1_op_a_i;
      sel_b   = req1_op_b_i;
      sel_sub = req1_sub_i;
    end
  end

  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  assign req0_ready_o = rst_n & (state == IDLE) & grant[0];
  assign req1_ready_o = rst_n & (state == IDLE) & grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cin_q       <= 1'b0;
      id_q        <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      prop_q      <= '0;
      rsp_valid_q <= 1'b0;
`ifdef ADD_SUBT_ARB_RR_EN
      last_q      <= ID_W'(1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            op_a_q <= sel_a;
            op_b_q <= sel_sub ? ~sel_b : sel_b;
            cin_q  <= sel_sub;
            id_q   <= gnt_id;
`ifdef ADD_SUBT_ARB_RR_EN
            last_q <= gnt_id;
`endif
            state  <= EXEC;
          end
        end
        EXEC: begin
          sum_q       <= add_sum_i;
          cout_q      <= add_cout_i;
          prop_q      <= add_prop_i;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign add_op_a_o  = op_a_q;
  assign add_op_b_o  = op_b_q;
  assign add_cin_o   = cin_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = id_q[0];
  assign rsp_sum_o   = sum_q;
  assign rsp_cout_o  = cout_q;
  assign rsp_prop_o  = prop_q;

endmodule
